// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - request/result bundle between an issuing pipeline and muldiv_sequencer
interface muldiv_sequencer_if;
  logic        START;
  logic        ABORT;
  logic [2:0]  OP;
  logic [63:0] X;
  logic [63:0] Y;
  logic        BUSY;
  logic        DONE;
  logic [63:0] RESULT;

  modport master (
    output START, ABORT, OP, X, Y,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, ABORT, OP, X, Y,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - fixed-latency radix-2 RV64 M-extension multiply/divide sequencer
module muldiv_sequencer (
  input  logic              CLK,
  input  logic              RESET_N,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FIX    = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] x_q, x_d;
  logic [63:0] y_q, y_d;
  logic [63:0] hi_q, hi_d;
  logic [63:0] lo_q, lo_d;
  logic [63:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        x_neg_in, y_neg_in;
  logic [63:0] lo_init;
  logic        x_neg, y_neg;
  logic [63:0] x_mag, y_mag;
  logic [64:0] mul_sum;
  logic [64:0] div_r;
  logic        div_ge;
  logic [63:0] div_rem;
  logic [127:0] prod_fix;
  logic [63:0] fix_result;

  function automatic logic x_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic y_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic [63:0] neg_if(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  // Both loops run on magnitudes; signs are folded back in FIX.
  always_comb begin
    x_neg_in = x_signed(bus.OP) & bus.X[63];
    y_neg_in = y_signed(bus.OP) & bus.Y[63];
    lo_init  = bus.OP[2] ? neg_if(bus.X, x_neg_in) : neg_if(bus.Y, y_neg_in);
    x_neg    = x_signed(op_q) & x_q[63];
    y_neg    = y_signed(op_q) & y_q[63];
    x_mag    = neg_if(x_q, x_neg);
    y_mag    = neg_if(y_q, y_neg);
  end

  // hi:lo holds product-so-far:multiplier, or partial-remainder:dividend/quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_mag} : 65'd0);
    div_r   = {hi_q, lo_q[63]};
    div_ge  = (div_r >= {1'b0, y_mag});
    div_rem = div_r[63:0] - y_mag;

    prod_fix = {hi_q, lo_q};
    if (x_neg ^ y_neg) begin
      prod_fix = ~prod_fix + 128'd1;
    end

    if (!op_q[2]) begin
      fix_result = (op_q == OP_MUL) ? prod_fix[63:0] : prod_fix[127:64];
    end else if (!op_q[1]) begin
      fix_result = (y_q == 64'd0) ? {64{1'b1}} : neg_if(lo_q, x_neg ^ y_neg);
    end else begin
      fix_result = (y_q == 64'd0) ? x_q : neg_if(hi_q, x_neg);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START && !bus.ABORT) begin
          op_d    = bus.OP;
          x_d     = bus.X;
          y_d     = bus.Y;
          cnt_d   = 6'd0;
          hi_d    = 64'd0;
          lo_d    = lo_init;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!op_q[2]) begin
          hi_d = mul_sum[64:1];
          lo_d = {mul_sum[0], lo_q[63:1]};
        end else begin
          hi_d = div_ge ? div_rem : div_r[63:0];
          lo_d = {lo_q[62:0], div_ge};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fix_result;
        done_d   = 1'b1;
        state_d  = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush wins over everything except a DONE already on the wire.
    if (bus.ABORT) begin
      state_d  = IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      x_q      <= 64'd0;
      y_q      <= 64'd0;
      hi_q     <= 64'd0;
      lo_q     <= 64'd0;
      result_q <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic CLK = 1'b0;
  logic RESET_N;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge (cycle 0); returns just after the falling edge of cycle 1.
  task automatic launch(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y);
    bus.OP    = op;
    bus.X     = x;
    bus.Y     = y;
    bus.START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.START = 1'b0;
    bus.OP    = ~op;
    bus.X     = ~x;
    bus.Y     = y ^ 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] x,
                        input logic [63:0] y, input logic [63:0] exp, input int poke_at);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    busy_cnt = 0;
    done_cnt = 0;
    done_cyc = 0;
    launch(op, x, y);
    for (int cyc = 1; cyc <= 67; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      if (cyc <= 66 && bus.BUSY) busy_cnt++;
      if (bus.DONE) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc = cyc;
      end
      if (cyc == 66) expect_eq({tag, " result"}, bus.RESULT, exp);
      if (cyc == poke_at) begin
        bus.START = 1'b1;
        bus.OP    = 3'd5;
        bus.X     = 64'd1000;
        bus.Y     = 64'd9;
      end else begin
        bus.START = 1'b0;
      end
    end
    expect_eq({tag, " busy cycles"}, 64'(busy_cnt), 64'd66);
    expect_eq({tag, " idle after"}, 64'(bus.BUSY), 64'd0);
    expect_eq({tag, " done count"}, 64'(done_cnt), 64'd1);
    expect_eq({tag, " done cycle"}, 64'(done_cyc), 64'd66);
  endtask

  initial begin
    int ab_done;
    int rst_done;
    int rst_busy;

    RESET_N   = 1'b0;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.OP    = 3'd0;
    bus.X     = 64'd0;
    bus.Y     = 64'd0;
    #1;
    expect_eq("reset busy", 64'(bus.BUSY), 64'd0);
    expect_eq("reset done", 64'(bus.DONE), 64'd0);
    expect_eq("reset result", bus.RESULT, 64'd0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    run_op("mul 3*-5", 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run_op("mulh -1*-1", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    run_op("mulhu max*max", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op("mulhsu -1*max", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("div 7/-2", 3'd4, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    run_op("rem -7%2", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("divu 5/0", 3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("remu 5%0", 3'd7, 64'd5, 64'd0, 64'd5, 0);
    run_op("div -7/0", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op("rem -7%0", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 0);
    run_op("div overflow", 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 0);
    run_op("rem overflow", 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
    run_op("divu max/2", 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 0);
    run_op("mul poke", 3'd0, 64'd6, 64'd7, 64'd42, 30);

    ab_done = 0;
    launch(3'd4, 64'd100, 64'd3);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge CLK);
      if (bus.DONE) ab_done++;
    end
    bus.ABORT = 1'b1;
    @(negedge CLK);
    if (bus.DONE) ab_done++;
    expect_eq("abort busy", 64'(bus.BUSY), 64'd0);
    expect_eq("abort done", 64'(ab_done), 64'd0);
    expect_eq("abort result", bus.RESULT, 64'd42);
    bus.ABORT = 1'b0;
    run_op("divu after abort", 3'd5, 64'd100, 64'd3, 64'd33, 0);

    bus.OP    = 3'd0;
    bus.X     = 64'd1;
    bus.Y     = 64'd1;
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    expect_eq("abort+start idle", 64'(bus.BUSY), 64'd0);

    launch(3'd0, 64'd5, 64'd5);
    repeat (19) @(negedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    expect_eq("async reset busy", 64'(bus.BUSY), 64'd0);
    expect_eq("async reset done", 64'(bus.DONE), 64'd0);
    expect_eq("async reset result", bus.RESULT, 64'd0);
    @(negedge CLK);
    RESET_N  = 1'b1;
    rst_done = 0;
    rst_busy = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge CLK);
      if (bus.DONE) rst_done++;
      if (bus.BUSY) rst_busy++;
    end
    expect_eq("post reset done", 64'(rst_done), 64'd0);
    expect_eq("post reset busy", 64'(rst_busy), 64'd0);
    run_op("remu 100%7", 3'd7, 64'd100, 64'd7, 64'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
